mac_norm_round_stage: RTL and testbench

Upstream neighbour of the exponent/subnormal handling stage in the MAC subsystem. Takes the aligned two's-complement accumulator sum and produces the fields that stage consumes:
- sign
- 11-bit mantissa with leading 1 at bit 10
- 5-bit signed exponent difference
- rounding carry

It is a 2-deep valid/ready pipeline and passes max_exp and Q_frac through alongside the data.

---
 rtl/mac_pkg.sv | 23 ++
 rtl/mac_lzd.sv | 25 ++
 rtl/mac_norm_round_stage.sv | 169 ++++++++++++++++
 tb/tb_mac_norm_round_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared widths, constants and cost figures for the MAC normalize/round path.
package mac_pkg;

    localparam int SUM_W      = 24;   // two's-complement accumulator sum width
    localparam int REF_POS    = 10;   // leading-one position meaning exponent difference 0
    localparam int MAN_W      = 11;   // normalized mantissa width including the leading 1
    localparam int EXP_DIFF_W = 5;    // signed exponent difference width
    localparam int MAX_EXP_W  = 6;    // pass-through max exponent width
    localparam int Q_FRAC_W   = 5;    // pass-through fraction scaling width
    localparam int NUMBER_W   = 51;   // width of the cell-cost count outputs
    localparam int POS_W      = 5;    // leading-one position width (0..SUM_W-1)

    // Cell-cost counts contributed by each block; the top sums them.
    localparam logic [NUMBER_W-1:0] LZD_CELL_COST = 51'd96;
    localparam logic [NUMBER_W-1:0] NRS_CELL_COST = 51'd412;

    // Magnitude of a two's-complement sum; the most negative value maps to
    // 2^(SUM_W-1), which is representable as an unsigned SUM_W-bit number.
    function automatic logic [SUM_W-1:0] abs_sum(input logic [SUM_W-1:0] value);
        return value[SUM_W-1] ? (~value + SUM_W'(1)) : value;
    endfunction

endpackage

// File: rtl/mac_lzd.sv
// Combinational leading-one detector over the accumulator magnitude.
module mac_lzd
    import mac_pkg::*;
(
    input  logic [SUM_W-1:0]    value,
    output logic [POS_W-1:0]    pos,
    output logic                zero,
    output logic [NUMBER_W-1:0] number
);

    // Scan upward so the highest set bit is the last one to win.
    always_comb begin
        pos  = '0;
        zero = 1'b1;
        for (int i = 0; i < SUM_W; i++) begin
            if (value[i]) begin
                pos  = POS_W'(i);
                zero = 1'b0;
            end
        end
    end

    assign number = LZD_CELL_COST;

endmodule

// File: rtl/mac_norm_round_stage.sv
// Two-stage valid/ready pipeline: magnitude + leading-one detect, then
// normalize with round-to-nearest-even, passing max_exp / Q_frac alongside.
module mac_norm_round_stage
    import mac_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SUM_W-1:0]      in_sum,
    input  logic [MAX_EXP_W-1:0]  in_max_exp,
    input  logic [Q_FRAC_W-1:0]   in_Q_frac,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MAN_W-1:0]      norm_sum_with_leading1,
    output logic [EXP_DIFF_W-1:0] signed_exp_diff,
    output logic                  exp_carry,
    output logic                  sign,
    output logic [MAX_EXP_W-1:0]  max_exp,
    output logic [Q_FRAC_W-1:0]   Q_frac,
    output logic [NUMBER_W-1:0]   number
);

    localparam logic [POS_W-1:0] REF_POS_L = POS_W'(REF_POS);

    // Stage 1 registers
    logic                 v1_reg;
    logic                 sign1_reg;
    logic                 zero1_reg;
    logic [POS_W-1:0]     pos1_reg;
    logic [SUM_W-1:0]     mag1_reg;
    logic [MAX_EXP_W-1:0] max_exp1_reg;
    logic [Q_FRAC_W-1:0]  q_frac1_reg;

    // Stage 2 (output) registers
    logic                  v2_reg;
    logic [MAN_W-1:0]      mant2_reg;
    logic [EXP_DIFF_W-1:0] diff2_reg;
    logic                  carry2_reg;
    logic                  sign2_reg;
    logic [MAX_EXP_W-1:0]  max_exp2_reg;
    logic [Q_FRAC_W-1:0]   q_frac2_reg;

    logic ready_s1;
    logic ready_s2;

    logic [SUM_W-1:0]    mag_next;
    logic [POS_W-1:0]    lzd_pos;
    logic                lzd_zero;
    logic [NUMBER_W-1:0] lzd_number;

    logic [MAN_W-1:0]      mant_next;
    logic [EXP_DIFF_W-1:0] diff_next;
    logic                  carry_next;
    logic [POS_W-1:0]      rshift;
    logic [POS_W-1:0]      lshift;
    logic [MAN_W-1:0]      trunc;
    logic                  guard;
    logic                  sticky;
    logic                  inc;
    logic [SUM_W-1:0]      sticky_mask;

    // A stage can take a new beat when empty or when its contents leave this cycle.
    assign ready_s2 = !v2_reg || out_ready;
    assign ready_s1 = !v1_reg || ready_s2;
    assign in_ready = ready_s1;

    assign mag_next = abs_sum(in_sum);

    mac_lzd u_lzd (
        .value  (mag_next),
        .pos    (lzd_pos),
        .zero   (lzd_zero),
        .number (lzd_number)
    );

    // Stage 1: capture sign, magnitude and leading-one position of the sum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_reg       <= 1'b0;
            sign1_reg    <= 1'b0;
            zero1_reg    <= 1'b0;
            pos1_reg     <= '0;
            mag1_reg     <= '0;
            max_exp1_reg <= '0;
            q_frac1_reg  <= '0;
        end else if (ready_s1) begin
            v1_reg <= in_valid;
            if (in_valid) begin
                sign1_reg    <= in_sum[SUM_W-1];
                zero1_reg    <= lzd_zero;
                pos1_reg     <= lzd_pos;
                mag1_reg     <= mag_next;
                max_exp1_reg <= in_max_exp;
                q_frac1_reg  <= in_Q_frac;
            end
        end
    end

    // Normalize the stage-1 magnitude to MAN_W bits, rounding to nearest even.
    always_comb begin
        mant_next   = '0;
        diff_next   = '0;
        carry_next  = 1'b0;
        rshift      = '0;
        lshift      = '0;
        trunc       = '0;
        guard       = 1'b0;
        sticky      = 1'b0;
        inc         = 1'b0;
        sticky_mask = '0;
        if (!zero1_reg) begin
            diff_next = EXP_DIFF_W'(pos1_reg - REF_POS_L);
            if (pos1_reg <= REF_POS_L) begin
                // Small values shift up exactly; nothing is lost.
                lshift    = REF_POS_L - pos1_reg;
                mant_next = MAN_W'(mag1_reg << lshift);
            end else begin
                // Large values drop rshift (>=1) low bits: guard is the top dropped bit,
                // sticky the OR of everything below it.
                rshift      = pos1_reg - REF_POS_L;
                trunc       = MAN_W'(mag1_reg >> rshift);
                guard       = mag1_reg[rshift - POS_W'(1)];
                sticky_mask = (SUM_W'(1) << (rshift - POS_W'(1))) - SUM_W'(1);
                sticky      = |(mag1_reg & sticky_mask);
                inc         = guard && (sticky || trunc[0]);
                if ((&trunc) && inc) begin
                    mant_next  = MAN_W'(1) << (MAN_W - 1);
                    carry_next = 1'b1;
                end else begin
                    mant_next = trunc + MAN_W'(inc);
                end
            end
        end
    end

    // Stage 2: register the rounded result; hold it while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_reg       <= 1'b0;
            mant2_reg    <= '0;
            diff2_reg    <= '0;
            carry2_reg   <= 1'b0;
            sign2_reg    <= 1'b0;
            max_exp2_reg <= '0;
            q_frac2_reg  <= '0;
        end else if (ready_s2) begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                mant2_reg    <= mant_next;
                diff2_reg    <= diff_next;
                carry2_reg   <= carry_next;
                sign2_reg    <= sign1_reg;
                max_exp2_reg <= max_exp1_reg;
                q_frac2_reg  <= q_frac1_reg;
            end
        end
    end

    assign out_valid              = v2_reg;
    assign norm_sum_with_leading1 = mant2_reg;
    assign signed_exp_diff        = diff2_reg;
    assign exp_carry              = carry2_reg;
    assign sign                   = sign2_reg;
    assign max_exp                = max_exp2_reg;
    assign Q_frac                 = q_frac2_reg;
    assign number                 = lzd_number + NRS_CELL_COST;

endmodule

// File: tb/tb_mac_norm_round_stage.sv
// Table-driven, scoreboarded bench for mac_norm_round_stage.
module tb_mac_norm_round_stage;

    typedef struct {
        logic [23:0] sum;
        logic [5:0]  max_exp;
        logic [4:0]  q;
        logic [10:0] mant;
        logic [4:0]  diff;
        logic        carry;
        logic        sign;
    } vec_t;

    localparam int NVEC = 14;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_sum;
    logic [5:0]  in_max_exp;
    logic [4:0]  in_Q_frac;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] norm_sum_with_leading1;
    logic [4:0]  signed_exp_diff;
    logic        exp_carry;
    logic        sign;
    logic [5:0]  max_exp;
    logic [4:0]  Q_frac;
    logic [50:0] number;

    vec_t vecs[NVEC];
    vec_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   cyc       = 0;
    bit   rand_bp   = 1'b0;

    mac_norm_round_stage dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .in_sum                 (in_sum),
        .in_max_exp             (in_max_exp),
        .in_Q_frac              (in_Q_frac),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .norm_sum_with_leading1 (norm_sum_with_leading1),
        .signed_exp_diff        (signed_exp_diff),
        .exp_carry              (exp_carry),
        .sign                   (sign),
        .max_exp                (max_exp),
        .Q_frac                 (Q_frac),
        .number                 (number)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Output monitor: pop the scoreboard on each completed output transfer.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("stale_beat", 64'(out_valid), 64'd0);
            end else begin
                vec_t e;
                e = exp_q.pop_front();
                $display("beat sum=%06h mant=%03h diff=%02h carry=%0d sign=%0d max_exp=%0d q=%0d",
                         e.sum, norm_sum_with_leading1, signed_exp_diff, exp_carry, sign, max_exp, Q_frac);
                check("mant",    64'(norm_sum_with_leading1), 64'(e.mant));
                check("diff",    64'(signed_exp_diff),        64'(e.diff));
                check("carry",   64'(exp_carry),              64'(e.carry));
                check("sign",    64'(sign),                   64'(e.sign));
                check("max_exp", 64'(max_exp),                64'(e.max_exp));
                check("q_frac",  64'(Q_frac),                 64'(e.q));
            end
        end
    end

    // Offer one beat until accepted (bounded); called at posedge+2.
    task automatic send(input vec_t v);
        int  n    = 0;
        bit  done = 1'b0;
        in_valid   = 1'b1;
        in_sum     = v.sum;
        in_max_exp = v.max_exp;
        in_Q_frac  = v.q;
        while (!done) begin
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(v);
                done = 1'b1;
            end else begin
                n++;
                if (n > 50) begin
                    check("send_timeout", 64'(in_ready), 64'd1);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_zero_state(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready"},  64'(in_ready),  64'd1);
        check({tag, "_mant"},      64'(norm_sum_with_leading1), 64'd0);
        check({tag, "_diff"},      64'(signed_exp_diff), 64'd0);
        check({tag, "_carry"},     64'(exp_carry), 64'd0);
        check({tag, "_sign"},      64'(sign), 64'd0);
        check({tag, "_max_exp"},   64'(max_exp), 64'd0);
        check({tag, "_q_frac"},    64'(Q_frac), 64'd0);
    endtask

    initial begin
        vec_t b0, b1, b2;
        int   c0;

        //          sum         me    q     mant     diff    c     s
        vecs[0]  = '{24'h000400, 6'd0, 5'd0, 11'h400, 5'h00, 1'b0, 1'b0};
        vecs[1]  = '{24'hFFFFFF, 6'd0, 5'd0, 11'h400, 5'h16, 1'b0, 1'b1};
        vecs[2]  = '{24'h800000, 6'd0, 5'd0, 11'h400, 5'h0D, 1'b0, 1'b1};
        vecs[3]  = '{24'h001FFF, 6'd0, 5'd0, 11'h400, 5'h02, 1'b1, 1'b0};
        vecs[4]  = '{24'h000801, 6'd0, 5'd0, 11'h400, 5'h01, 1'b0, 1'b0};
        vecs[5]  = '{24'h000803, 6'd0, 5'd0, 11'h402, 5'h01, 1'b0, 1'b0};
        vecs[6]  = '{24'h000000, 6'd0, 5'd0, 11'h000, 5'h00, 1'b0, 1'b0};
        vecs[7]  = '{24'h000005, 6'd0, 5'd0, 11'h500, 5'h18, 1'b0, 1'b0};
        vecs[8]  = '{24'hFFF7FD, 6'd0, 5'd0, 11'h402, 5'h01, 1'b0, 1'b1};
        vecs[9]  = '{24'h000C02, 6'd0, 5'd0, 11'h601, 5'h01, 1'b0, 1'b0};
        vecs[10] = '{24'h001803, 6'd0, 5'd0, 11'h601, 5'h02, 1'b0, 1'b0};
        vecs[11] = '{24'h7FFFFF, 6'd0, 5'd0, 11'h400, 5'h0C, 1'b1, 1'b0};
        vecs[12] = '{24'h000A00, 6'd0, 5'd0, 11'h500, 5'h01, 1'b0, 1'b0};
        vecs[13] = '{24'h001806, 6'd0, 5'd0, 11'h602, 5'h02, 1'b0, 1'b0};
        for (int i = 0; i < NVEC; i++) begin
            vecs[i].max_exp = 6'(i * 4 + 3);
            vecs[i].q       = 5'(31 - i);
        end

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sum     = '0;
        in_max_exp = '0;
        in_Q_frac  = '0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check_zero_state("reset");
        check("number", 64'(number), 64'd508);
        @(posedge clk);
        #2;

        // Full-rate stream of the table: one accept per cycle expected
        c0 = cyc;
        for (int i = 0; i < NVEC; i++) send(vecs[i]);
        check("throughput_cycles", 64'(cyc - c0), 64'(NVEC));
        drain();

        // Backpressure: two accepts fill the pipe, third is held off
        b0 = vecs[3];  b0.max_exp = 6'h11; b0.q = 5'h01;
        b1 = vecs[7];  b1.max_exp = 6'h22; b1.q = 5'h02;
        b2 = vecs[13]; b2.max_exp = 6'h33; b2.q = 5'h03;
        out_ready = 1'b0;
        send(b0);
        send(b1);
        in_valid   = 1'b1;
        in_sum     = b2.sum;
        in_max_exp = b2.max_exp;
        in_Q_frac  = b2.q;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            check("bp_out_valid",    64'(out_valid), 64'd1);
            check("bp_hold_mant",    64'(norm_sum_with_leading1), 64'(b0.mant));
            check("bp_hold_max_exp", 64'(max_exp), 64'(b0.max_exp));
            @(posedge clk);
            #2;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_resume_in_ready", 64'(in_ready), 64'd1);
        if (in_ready) exp_q.push_back(b2);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("bp_consecutive", 64'(out_valid), 64'd1);
            @(posedge clk);
            #2;
        end
        drain();

        // Reset with both stages full: nothing stale may emerge afterwards
        out_ready = 1'b0;
        send(vecs[4]);
        send(vecs[5]);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_zero_state("midreset");
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        send(vecs[11]);
        drain();

        // Table again under random backpressure
        rand_bp = 1'b1;
        for (int i = NVEC - 1; i >= 0; i--) send(vecs[i]);
        rand_bp = 1'b0;
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
